axis_c_requant: RTL

Streaming requantizer directly downstream of the systolic-array matrix engine's C output. It accepts the row-major M×L result stream of signed 16-bit elements and multiplies each element by a per-frame unsigned scale. It then applies a rounding arithmetic right shift, saturates to signed 8-bit and emits the result as an AXIS stream. The output feeds the next layer's A-matrix loader. It regenerates `tlast` from its own element counters and flags framing mismatches on the input.

---
 rtl/axis_c_requant.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axis_c_requant.sv
// Streaming requantizer: signed C element x per-frame scale, rounding shift, saturate to QW bits.
// Optional build macro REQUANT_RELU_EN clamps negative results to zero before saturation.
module axis_c_requant #(
  parameter int M  = 25,
  parameter int L  = 17,
  parameter int IW = 16,
  parameter int QW = 8,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] cfg_scale,
  input  logic [4:0]    cfg_shift,
  input  logic [IW-1:0] s_axis_c_tdata,
  input  logic          s_axis_c_tvalid,
  output logic          s_axis_c_tready,
  input  logic          s_axis_c_tlast,
  output logic [QW-1:0] m_axis_q_tdata,
  output logic          m_axis_q_tvalid,
  input  logic          m_axis_q_tready,
  output logic          m_axis_q_tlast,
  output logic          err_tlast,
  output logic [15:0]   sat_cnt
);

  localparam int PW    = IW + SW + 1;
  localparam int EW    = PW + 1;
  localparam int CW    = $clog2(L);
  localparam int RBW   = $clog2(M);
  localparam int QMAXI = (1 << (QW - 1)) - 1;
  localparam int QMINI = -(1 << (QW - 1));

  logic [CW-1:0]  col;
  logic [RBW-1:0] row;
  logic [SW-1:0]  scale_q;
  logic [4:0]     shift_q;

  logic                 v1, v2;
  logic signed [PW-1:0] p1;
  logic [4:0]           sh1;
  logic                 last1;

  logic ld2, adv1, acc, first, at_end;
  logic [SW-1:0]        eff_scale;
  logic [4:0]           eff_shift;
  logic signed [PW-1:0] a_ext, b_ext, p_next;
  logic signed [EW-1:0] p_ext, rnd, r;
  logic [QW-1:0]        q_next;
  logic                 clip;

  assign ld2    = !v2 || m_axis_q_tready;
  assign adv1   = v1 && ld2;
  // Gated by rst_n so the input looks not-ready for exactly the reset cycles.
  assign s_axis_c_tready = rst_n && (!v1 || adv1);
  assign acc    = s_axis_c_tvalid && s_axis_c_tready;

  assign first  = (row == '0) && (col == '0);
  assign at_end = (row == RBW'(M - 1)) && (col == CW'(L - 1));

  // The first beat of a frame must already use the config being latched with it.
  assign eff_scale = first ? cfg_scale : scale_q;
  assign eff_shift = first ? cfg_shift : shift_q;

  assign a_ext  = PW'($signed(s_axis_c_tdata));
  assign b_ext  = PW'($signed({1'b0, eff_scale}));
  assign p_next = a_ext * b_ext;

  always_comb begin
    p_ext  = EW'(p1);
    rnd    = EW'(1) <<< (sh1 - 5'd1);
    r      = (sh1 == 5'd0) ? p_ext : ((p_ext + rnd) >>> sh1);
    q_next = r[QW-1:0];
    clip   = 1'b0;
`ifdef REQUANT_RELU_EN
    if (r[EW-1]) begin
      q_next = '0;
    end else if (r > EW'(QMAXI)) begin
      q_next = QW'(QMAXI);
      clip   = 1'b1;
    end
`else
    if (r > EW'(QMAXI)) begin
      q_next = QW'(QMAXI);
      clip   = 1'b1;
    end else if (r < EW'(QMINI)) begin
      q_next = QW'(QMINI);
      clip   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col             <= '0;
      row             <= '0;
      scale_q         <= '0;
      shift_q         <= '0;
      v1              <= 1'b0;
      p1              <= '0;
      sh1             <= '0;
      last1           <= 1'b0;
      v2              <= 1'b0;
      m_axis_q_tdata  <= '0;
      m_axis_q_tlast  <= 1'b0;
      err_tlast       <= 1'b0;
      sat_cnt         <= '0;
    end else begin
      if (acc) begin
        if (col == CW'(L - 1)) begin
          col <= '0;
          row <= (row == RBW'(M - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (first) begin
          scale_q <= cfg_scale;
          shift_q <= cfg_shift;
        end
        if (s_axis_c_tlast != at_end)
          err_tlast <= 1'b1;
      end

      if (s_axis_c_tready) begin
        v1 <= s_axis_c_tvalid;
        if (acc) begin
          p1    <= p_next;
          sh1   <= eff_shift;
          last1 <= at_end;
        end
      end

      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          m_axis_q_tdata <= q_next;
          m_axis_q_tlast <= last1;
          if (clip && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
        end
      end
    end
  end

  assign m_axis_q_tvalid = v2;

endmodule
